// File: rtl/fifo_block_unpacker.sv
// Pops 128-bit blocks from the block FIFO and streams them out MSB-first as words.
// Optional macro FIFO_UNPACK_PREFETCH_EN: pop the next block on the last-word accept.
module fifo_block_unpacker #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned WORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [BLOCK_W-1:0] fifo_data,
  output logic               fifo_read,
  output logic [WORD_W-1:0]  word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               word_last,
  output logic [15:0]        block_count
);

  localparam int unsigned N     = BLOCK_W / WORD_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [15:0]        block_count_q, block_count_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    block_count_d = block_count_q;
    fifo_read     = 1'b0;
    case (state_q)
      S_IDLE: begin
        fifo_read = ~fifo_empty;
        if (!fifo_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d = fifo_data;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            block_count_d = block_count_q + 16'd1;
`ifdef FIFO_UNPACK_PREFETCH_EN
            fifo_read = ~fifo_empty;
            state_d   = fifo_empty ? S_IDLE : S_WAIT;
`else
            state_d   = S_IDLE;
`endif
          end else begin
            shreg_d = shreg_q << WORD_W;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The held block is discarded during reset, so never pop in that cycle.
    if (rst) fifo_read = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      shreg_q       <= '0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      block_count_q <= block_count_d;
    end
  end

  assign word_valid  = (state_q == S_SEND);
  assign word_last   = (state_q == S_SEND) && (idx_q == LAST_IDX);
  assign word_out    = shreg_q[BLOCK_W-1 -: WORD_W];
  assign block_count = block_count_q;

endmodule

// File: tb/tb_fifo_block_unpacker.sv
// Randomized bench for fifo_block_unpacker against a queue-based FIFO and word model.
module tb_fifo_block_unpacker;

  localparam int unsigned BW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned N  = BW / WW;
`ifdef FIFO_UNPACK_PREFETCH_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [BW-1:0] fifo_data = '0;
  logic          fifo_read;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          word_last;
  logic [15:0]   block_count;

  always #5 clk = ~clk;

  fifo_block_unpacker #(.BLOCK_W(BW), .WORD_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .block_count(block_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [WW-1:0] w;
    int unsigned   idx;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] inq[$];
  logic [BW-1:0] fq[$];
  int unsigned   pops = 0;

  task automatic push_block(input logic [BW-1:0] b);
    exp_t e;
    inq.push_back(b);
    for (int unsigned i = 0; i < N; i++) begin
      e.w   = b[BW-1-WW*i -: WW];
      e.idx = i;
      exp_q.push_back(e);
    end
  endtask

  // Behavioural FIFO: registered empty flag, data valid the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_read && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      pops++;
    end
    while (inq.size() > 0) fq.push_back(inq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  int          cyc = 0;
  int          pop_cyc = 0;
  int          last_cyc = 0;
  bit          last_valid = 0;
  bit          gap_en = 0;
  bit          first_done = 0;
  bit          hold = 0;
  bit          post_rst = 0;
  logic [WW-1:0] hold_w;
  logic        hold_l;
  logic [15:0] mcnt = '0;

  always @(negedge clk) begin
    cyc++;
    check("rd_while_empty", fifo_read & fifo_empty, 0);
    if (rst) begin
      check("rd_in_rst", fifo_read, 0);
      while (exp_q.size() > 0 && exp_q[0].idx != 0) void'(exp_q.pop_front());
      mcnt = '0;
      hold = 0;
      first_done = 0;
      post_rst = 1;
    end else begin
      if (post_rst) begin
        check("valid_after_rst", word_valid, 0);
        check("count_after_rst", block_count, 0);
        post_rst = 0;
      end
      check("block_count", block_count, mcnt);
      if (hold) begin
        check("stall_valid", word_valid, 1);
        check("stall_word", word_out, hold_w);
        check("stall_last", word_last, hold_l);
      end
      hold = 0;
      if (fifo_read) pop_cyc = cyc;
      if (word_valid) begin
        if (exp_q.size() == 0) check("spurious_word", 1, 0);
        else begin
          if (exp_q[0].idx == 0 && !first_done) begin
            first_done = 1;
            check("first_latency", cyc - pop_cyc, 2);
            if (gap_en && last_valid) check("block_gap", cyc - last_cyc, GAP);
          end
          if (word_ready) begin
            check("word", word_out, exp_q[0].w);
            check("last", word_last, exp_q[0].idx == N - 1);
            if (exp_q[0].idx == N - 1) begin
              mcnt++;
              last_cyc = cyc;
              last_valid = 1;
            end
            first_done = 0;
            void'(exp_q.pop_front());
          end else begin
            hold = 1;
            hold_w = word_out;
            hold_l = word_last;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || word_valid || inq.size() > 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("drain_timeout", 1, 0);
    repeat (3) step();
  endtask

  initial begin
    bit [6:0] pat = 7'b1101001;
    int k;
    int sent;

    repeat (2) step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_read", fifo_read, 0);
      check("idle_valid", word_valid, 0);
      check("idle_count", block_count, 0);
      check("idle_word", word_out, 0);
      check("idle_last", word_last, 0);
    end

    word_ready = 1'b1;
    pops = 0;
    push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wait_drain(50);
    check("count_one", block_count, 1);
    check("pops_one", pops, 1);

    pops = 0;
    push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    k = 0;
    while ((exp_q.size() > 0 || inq.size() > 0) && k < 80) begin
      word_ready = pat[6 - (k % 7)];
      step();
      k++;
    end
    if (k >= 80) check("stall_timeout", 1, 0);
    word_ready = 1'b1;
    repeat (3) step();
    check("stall_pops", pops, 1);
    check("count_two", block_count, 2);

    last_valid = 0;
    gap_en = 1;
    for (int i = 0; i < 3; i++) push_block({$urandom, $urandom, $urandom, $urandom});
    wait_drain(100);
    gap_en = 0;
    check("count_five", block_count, 5);

    push_block({$urandom, $urandom, $urandom, $urandom});
    push_block({$urandom, $urandom, $urandom, $urandom});
    k = 0;
    while (exp_q.size() > 2 * N - 2 && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) check("rst_wait_timeout", 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_drain(100);
    check("count_after_rst_block", block_count, 1);

    sent = 0;
    k = 0;
    while ((sent < 40 || exp_q.size() > 0) && k < 3000) begin
      word_ready = ($urandom % 4) != 0;
      if (sent < 40 && ($urandom % 3) == 0) begin
        push_block({$urandom, $urandom, $urandom, $urandom});
        sent++;
      end
      step();
      k++;
    end
    if (k >= 3000) check("random_timeout", 1, 0);
    word_ready = 1'b1;
    wait_drain(100);
    check("count_random", block_count, 41);

    force dut.block_count_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    step();
    release dut.block_count_q;
    step();
    check("count_preload", block_count, 16'hFFFF);
    push_block({$urandom, $urandom, $urandom, $urandom});
    wait_drain(50);
    check("count_wrap", block_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
